// File: rtl/imem_stall_responder_pkg.sv
// Shared definitions for the instruction-memory stall responder and its
// requesters: FSM state encoding, default latency/address width, counter width.
package imem_stall_responder_pkg;

  localparam int LAT_DEFAULT = 3;
  localparam int AW_DEFAULT  = 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } rsp_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } rsp_op_e;

  function automatic logic [CNT_W-1:0] lat_load_val(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/imem_stall_responder_lat_counter.sv
// Latency down-counter: load, decrement-while-nonzero, zero flag.
// Ports: clk, rst (sync, active-high), load_i/load_val_i, dec_i, cnt_o, zero_o.
module dff_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

module lat_counter
  import imem_stall_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             en;

  assign zero_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    en    = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
      en    = 1'b1;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - CNT_W'(1);
      en    = 1'b1;
    end
  end

  dff_reg #(
    .W(CNT_W)
  ) u_cnt_reg (
    .clk (clk),
    .rst (rst),
    .en_i(en),
    .d_i (cnt_d),
    .q_o (cnt_q)
  );

  assign cnt_o = cnt_q;

endmodule

// File: rtl/imem_stall_responder.sv
// Multi-cycle instruction memory responder: stalls LATENCY cycles per access.
// Ports: clk, rst, addr, rd, wr, data_in -> data_out, stall, done, err.
module imem_stall_responder
  import imem_stall_responder_pkg::*;
#(
  parameter int LATENCY = LAT_DEFAULT,
  parameter int AW      = AW_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int DEPTH = 1 << AW;

  rsp_state_e state_q;
  rsp_state_e state_d;

  logic [AW-1:0]    idx_q;
  logic [15:0]      wdata_q;
  rsp_op_e          op_q;
  logic [15:0]      dout_q;
  logic             stall_q;
  logic             done_q;
  logic             err_q;
  logic [15:0]      mem_q [DEPTH];

  logic             req_ok;
  logic             req_bad;
  logic             accept;
  logic             reject;
  logic             lat_load;
  logic             lat_dec;
  logic             lat_zero;
  logic             commit;
  logic [CNT_W-1:0] lat_cnt;

  // Exactly one op, halfword aligned.
  assign req_ok  = (rd ^ wr) && !addr[0];
  assign req_bad = (rd | wr) && !req_ok;

  lat_counter u_lat (
    .clk       (clk),
    .rst       (rst),
    .load_i    (lat_load),
    .load_val_i(lat_load_val(LATENCY)),
    .dec_i     (lat_dec),
    .cnt_o     (lat_cnt),
    .zero_o    (lat_zero)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req_ok) begin
          accept   = 1'b1;
          lat_load = 1'b1;
          state_d  = ST_BUSY;
        end else begin
          reject  = req_bad;
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (lat_zero) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end else begin
          lat_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
      dout_q  <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= (state_d == ST_BUSY);
      done_q  <= (state_d == ST_DONE);
      err_q   <= reject;
      if (accept) begin
        idx_q   <= addr[AW:1];
        wdata_q <= data_in;
        op_q    <= wr ? OP_WR : OP_RD;
      end
      if (commit && op_q == OP_RD) begin
        dout_q <= mem_q[idx_q];
      end
    end
  end

  // Write lands on the BUSY->DONE edge, so any later read sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && op_q == OP_WR) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign data_out = dout_q;
  assign stall    = stall_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_stall_responder.sv
// Self-checking bench for imem_stall_responder: directed table, corner
// sequences and randomized traffic against a timeline-based reference model.
module tb_imem_stall_responder;

  localparam int L = 3;
  localparam int A = 8;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  int errors;
  int checks;

  imem_stall_responder #(
    .LATENCY(L),
    .AW     (A)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .rd      (rd),
    .wr      (wr),
    .data_in (data_in),
    .data_out(data_out),
    .stall   (stall),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an access accepted at edge acc_t stalls for the next
  // L cycles, commits at edge acc_t+L, and reports done right after it.
  logic [15:0] m_mem [1<<A];
  logic [15:0] m_dout;
  bit          m_err;
  int          t_edge;
  int          acc_t;
  bit          m_wr;
  int          m_idx;
  logic [15:0] m_wd;

  task automatic model_edge(input logic r, input logic rv, input logic wv,
                            input logic [15:0] a, input logic [15:0] d);
    t_edge++;
    if (r) begin
      foreach (m_mem[i]) m_mem[i] = 16'h0;
      m_dout = 16'h0;
      m_err  = 1'b0;
      acc_t  = -1;
      return;
    end
    m_err = 1'b0;
    if (acc_t >= 0 && t_edge == acc_t + L) begin
      if (m_wr) m_mem[m_idx] = m_wd;
      else      m_dout = m_mem[m_idx];
    end
    if (acc_t < 0 || t_edge > acc_t + L) begin
      if ((rv != wv) && !a[0]) begin
        acc_t = t_edge;
        m_wr  = wv;
        m_idx = (a / 2) % (1 << A);
        m_wd  = d;
      end else if (rv || wv) begin
        m_err = 1'b1;
      end
    end
  endtask

  function automatic bit m_stall();
    return acc_t >= 0 && (t_edge - acc_t) < L;
  endfunction

  function automatic bit m_done();
    return acc_t >= 0 && (t_edge - acc_t) == L;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic wv,
                      input logic [15:0] a, input logic [15:0] d);
    rst = r; rd = rv; wr = wv; addr = a; data_in = d;
    @(posedge clk);
    model_edge(r, rv, wv, a, d);
    #1;
    chk("stall", 16'(stall), 16'(m_stall()));
    chk("done", 16'(done), 16'(m_done()));
    chk("err", 16'(err), 16'(m_err));
    chk("data_out", data_out, m_dout);
    if (done && err) chk("done_err_excl", 16'(1), 16'(0));
    if (done && stall) chk("done_stall_excl", 16'(1), 16'(0));
  endtask

  typedef struct {
    logic        r;
    logic        rv;
    logic        wv;
    logic [15:0] a;
    logic [15:0] d;
    logic        e_stall;
    logic        e_done;
    logic        e_err;
    logic [15:0] e_dout;
  } vec_t;

  vec_t vt [25];
  int   done_cnt;

  initial begin
    errors = 0; checks = 0;
    t_edge = 0; acc_t = -1; m_dout = 16'h0; m_err = 0;
    m_wr = 0; m_idx = 0; m_wd = 16'h0;
    foreach (m_mem[i]) m_mem[i] = 16'h0;
    rst = 1; rd = 0; wr = 0; addr = 0; data_in = 0;

    //          r  rd wr addr      din       st dn er dout
    vt[0]  = '{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000};
    vt[1]  = '{0, 1, 0, 16'h0004, 16'h0000, 1, 0, 0, 16'h0000};
    vt[2]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000};
    vt[3]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000};
    vt[4]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000};
    vt[5]  = '{0, 0, 1, 16'h0010, 16'hBEEF, 1, 0, 0, 16'h0000};
    vt[6]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000};
    vt[7]  = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000};
    vt[8]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000};
    vt[9]  = '{0, 1, 0, 16'h0010, 16'h0000, 1, 0, 0, 16'h0000};
    vt[10] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000};
    vt[11] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000};
    vt[12] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF};
    vt[13] = '{0, 1, 0, 16'h0003, 16'h0000, 0, 0, 1, 16'hBEEF};
    vt[14] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hBEEF};
    vt[15] = '{0, 1, 1, 16'h0002, 16'h0000, 0, 0, 1, 16'hBEEF};
    vt[16] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'hBEEF};
    vt[17] = '{0, 0, 1, 16'h0202, 16'h1234, 1, 0, 0, 16'hBEEF};
    vt[18] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF};
    vt[19] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF};
    vt[20] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF};
    vt[21] = '{0, 1, 0, 16'h0002, 16'h0000, 1, 0, 0, 16'hBEEF};
    vt[22] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF};
    vt[23] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'hBEEF};
    vt[24] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h1234};

    for (int i = 0; i < 25; i++) begin
      step(vt[i].r, vt[i].rv, vt[i].wv, vt[i].a, vt[i].d);
      chk($sformatf("vec%0d_stall", i), 16'(stall), 16'(vt[i].e_stall));
      chk($sformatf("vec%0d_done", i), 16'(done), 16'(vt[i].e_done));
      chk($sformatf("vec%0d_err", i), 16'(err), 16'(vt[i].e_err));
      chk($sformatf("vec%0d_dout", i), data_out, vt[i].e_dout);
    end

    // Reset during BUSY aborts a write: no done, no committed data.
    step(0, 0, 0, 16'h0, 16'h0);
    step(0, 0, 1, 16'h0020, 16'hAAAA);
    step(0, 0, 0, 16'h0, 16'h0);
    step(1, 0, 0, 16'h0, 16'h0);
    chk("abort_stall", 16'(stall), 16'(0));
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 16'h0, 16'h0);
      done_cnt += int'(done);
    end
    chk("abort_no_done", 16'(done_cnt), 16'(0));
    step(0, 1, 0, 16'h0020, 16'h0);
    for (int i = 0; i < L; i++) step(0, 0, 0, 16'h0, 16'h0);
    chk("abort_rd_done", 16'(done), 16'(1));
    chk("abort_rd_data", data_out, 16'h0000);

    // Requests during BUSY are ignored: one done per accepted access.
    step(0, 0, 0, 16'h0, 16'h0);
    step(0, 1, 0, 16'h0004, 16'h0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < L - 1) step(0, 1, 0, 16'h0006, 16'h0);
      else           step(0, 0, 0, 16'h0, 16'h0);
      done_cnt += int'(done);
    end
    chk("busy_ignore_one_done", 16'(done_cnt), 16'(1));

    // Requests while rst is high are ignored.
    step(1, 1, 0, 16'h0004, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("rst_req_ignored", 16'(stall), 16'(0));

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      logic        r;
      logic        rv;
      logic        wv;
      int          k;
      a = 16'($urandom);
      a[4:1] = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
      k  = $urandom_range(0, 15);
      rv = (k < 6) || (k == 15);
      wv = (k >= 6 && k < 11) || (k == 15);
      r  = ($urandom_range(0, 79) == 0);
      step(r, rv, wv, a, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_stall_responder.md
IMEM_STALL_RESPONDER -- requirements
Module: imem_stall_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3, number of busy cycles per access (legal 1..15).
REQ-002 SHALL have parameter AW, default 8, word-address bits (storage depth 2^AW 16-bit words).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port addr  input  16  byte address from fetch/requester.
REQ-006 SHALL have port rd  input  1  read request, sampled when idle-capable.
REQ-007 SHALL have port wr  input  1  write request, sampled when idle-capable.
REQ-008 SHALL have port data_in  input  16  write data.
REQ-009 SHALL have port data_out  output  16  read data, registered, valid when done=1, held until next read completes.
REQ-010 SHALL have port stall  output  1  high while an access is in progress (BUSY).
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  one-cycle pulse for rejected request.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; all outputs registered.
REQ-014 SHALL sample requests only in IDLE or DONE ("idle-capable"); rd/wr asserted in BUSY SHALL be ignored.
REQ-015 SHALL accept a request when exactly one of rd/wr is high and addr[0]=0: latch addr, data_in, op; load counter with LATENCY-1; next state BUSY.
REQ-016 SHALL reject rd&wr both high, or addr[0]=1 with rd|wr: no storage access, err=1 next cycle, next state IDLE.
REQ-017 SHALL index storage with addr[AW:1]; upper address bits ignored (wrap-around modulo 2^AW words).
REQ-018 In BUSY SHALL decrement counter while nonzero; at counter=0 SHALL go to DONE; BUSY lasts exactly LATENCY cycles.
REQ-019 Request sampled in cycle T SHALL give stall=1 in cycles T+1..T+LATENCY and done=1 in cycle T+LATENCY+1.
REQ-020 Read SHALL load data_out with word at latched index on the BUSY->DONE edge.
REQ-021 Write SHALL update storage on the BUSY->DONE edge; data_out unchanged by writes.
REQ-022 Read following write to same address SHALL return the new data (no stale read).
REQ-023 In DONE, valid request SHALL be accepted (back-to-back, no bubble); otherwise next state IDLE.
REQ-024 done, err SHALL never be high in the same cycle; stall and done SHALL never be high together.

Reset
REQ-025 rst=1 SHALL force state IDLE, counter 0, data_out=16'h0000, stall=0, done=0, err=0.
REQ-026 rst=1 SHALL clear all storage words to 16'h0000.
REQ-027 rst during BUSY SHALL abort the access: no write committed, no done pulse.
REQ-028 Requests presented while rst=1 SHALL be ignored.

Structure
REQ-029 State encodings and LATENCY/AW defaults SHALL live in a shared package/include used by fetch-side and responder.
REQ-030 Latency down-counter SHALL be one sub-module, lat_counter (load, decrement, zero flag), built on the existing register flop module.
REQ-031 Storage SHALL be a flop array inside imem_stall_responder; no vendor macros.

Verification
REQ-032 Reset, then rd addr=16'h0004 in cycle 0 -> stall=1 cycles 1-3, done=1 cycle 4, data_out=16'h0000.
REQ-033 wr addr=16'h0010 data_in=16'hBEEF, then rd same addr immediately in DONE cycle -> second done 4 cycles later, data_out=16'hBEEF, no idle bubble.
REQ-034 rd addr=16'h0003 -> err=1 next cycle, stall=0, done never asserts; rd&wr both high at addr 16'h0002 -> same.
REQ-035 wr addr=16'h0202 data 16'h1234 (AW=8) then rd addr=16'h0002 -> data_out=16'h1234 (wrap).
REQ-036 wr addr=16'h0020 data 16'hAAAA, rst=1 in cycle 2 of BUSY, then rd 16'h0020 -> data_out=16'h0000, no done from aborted write.
REQ-037 New rd issued during BUSY -> ignored; exactly one done pulse per accepted request.
